// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master. Converts a valid/ready command into APB SETUP/ACCESS
// phases and returns status as a one-cycle response pulse.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic              pwrite_o,
    output logic              psel_o,
    output logic              penable_o,
    input  logic              pready_i,
    input  logic              pslverr_i,
    input  logic [DATA_W-1:0] prdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    write_d = cmd_write_i;
                    // Misaligned commands are answered from ERR without touching the bus
                    if (cmd_addr_i[1:0] != 2'b00) begin
                        state_d       = S_ERR;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                wait_cnt_d = '0;
                state_d    = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready_i) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!write_q && !pslverr_i) ? prdata_i : '0;
                end else if (timeout_hit) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable_o     = (state_q == S_ACCESS);
    assign paddr_o       = addr_q;
    assign pwdata_o      = wdata_q;
    assign pwrite_o      = write_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs driven and outputs sampled on negedge.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk_i(clk), .preset_i(preset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel),
        .penable_o(penable), .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
    );

    // Issues one command and plays the slave; waits<0 means pready never rises.
    // Returns on the negedge where rsp_valid is seen, or with got=0 after the budget.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input logic err, input logic [31:0] rd,
                           output int n_psel, output int n_pen, output int lat,
                           output logic got, output logic addr_ok);
        n_psel  = 0;
        n_pen   = 0;
        lat     = 0;
        got     = 1'b0;
        addr_ok = 1'b1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (rsp_valid) begin
                lat = k; got = 1'b1;
                pready = 1'b0; pslverr = 1'b0; prdata = '0;
                break;
            end
            if (psel) begin
                n_psel++;
                if (paddr !== a || pwrite !== w || (w && pwdata !== d)) addr_ok = 1'b0;
            end
            if (penable) begin
                n_pen++;
                if (waits >= 0 && n_pen > waits) begin
                    pready = 1'b1; pslverr = err; prdata = rd;
                end
            end
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL reset_psel got=%b%b exp=00", psel, penable); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b%b%b exp=000", rsp_valid, rsp_err, rsp_timeout); end
        total++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_bus paddr=%h pwdata=%h rdata=%h exp=0", paddr, pwdata, rsp_rdata); end
        preset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_wait();
        int np, ne, lat; logic got, aok;
        do_xfer(1'b1, 32'h04, 32'h20250101, 1, 1'b0, 32'h0, np, ne, lat, got, aok);
        total++; if (!got) begin bad++; $display("FAIL write_rsp no response"); end
        total++; if (np != 3 || ne != 2) begin bad++; $display("FAIL write_phases psel=%0d pen=%0d exp=3/2", np, ne); end
        total++; if (!aok) begin bad++; $display("FAIL write_bus paddr/pwdata/pwrite unstable or wrong"); end
        total++; if (lat != 4) begin bad++; $display("FAIL write_latency got=%0d exp=4", lat); end
        total++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL write_status err=%b to=%b rdata=%h exp=0/0/0", rsp_err, rsp_timeout, rsp_rdata); end
        total++; if (psel !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL write_idle psel=%b ready=%b exp=0/1", psel, cmd_ready); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL write_pulse rsp_valid=%b exp=0", rsp_valid); end
    endtask

    task automatic test_read_back_to_back();
        int np, ne, lat; logic got, aok;
        do_xfer(1'b0, 32'h0C, 32'h0, 0, 1'b0, 32'h494D4A41, np, ne, lat, got, aok);
        total++; if (!got || rsp_rdata !== 32'h494D4A41 || rsp_err !== 1'b0) begin bad++; $display("FAIL read_data got=%h err=%b exp=494d4a41/0", rsp_rdata, rsp_err); end
        total++; if (lat != 3 || np != 2 || ne != 1) begin bad++; $display("FAIL read_timing lat=%0d psel=%0d pen=%0d exp=3/2/1", lat, np, ne); end
        // Next command issued in the completion cycle: must also finish in 3
        do_xfer(1'b0, 32'h08, 32'h0, 0, 1'b0, 32'h19990707, np, ne, lat, got, aok);
        total++; if (!got || lat != 3 || rsp_rdata !== 32'h19990707) begin bad++; $display("FAIL b2b lat=%0d rdata=%h exp=3/19990707", lat, rsp_rdata); end
        total++; if (!aok) begin bad++; $display("FAIL b2b_bus paddr wrong during transfer"); end
    endtask

    task automatic test_slverr();
        int np, ne, lat; logic got, aok;
        do_xfer(1'b0, 32'h10, 32'h0, 0, 1'b1, 32'hDEADBEEF, np, ne, lat, got, aok);
        total++; if (!got || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL slverr err=%b to=%b rdata=%h exp=1/0/0", rsp_err, rsp_timeout, rsp_rdata); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin bad++; $display("FAIL slverr_hold valid=%b err=%b exp=0/1", rsp_valid, rsp_err); end
    endtask

    task automatic test_timeout();
        int np, ne, lat; logic got, aok;
        do_xfer(1'b0, 32'h00, 32'h0, -1, 1'b0, 32'h0, np, ne, lat, got, aok);
        total++; if (!got) begin bad++; $display("FAIL timeout no response within budget"); end
        total++; if (ne != 16 || lat != 18) begin bad++; $display("FAIL timeout_len pen=%0d lat=%0d exp=16/18", ne, lat); end
        total++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin bad++; $display("FAIL timeout_status err=%b to=%b rdata=%h psel=%b exp=1/1/0/0", rsp_err, rsp_timeout, rsp_rdata, psel); end
    endtask

    task automatic test_unaligned();
        int np, ne, lat; logic got, aok;
        do_xfer(1'b1, 32'h06, 32'h12345678, 0, 1'b0, 32'h0, np, ne, lat, got, aok);
        total++; if (!got || lat != 1 || np != 0) begin bad++; $display("FAIL unaligned lat=%0d psel=%0d exp=1/0", lat, np); end
        total++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || psel !== 1'b0) begin bad++; $display("FAIL unaligned_status err=%b to=%b psel=%b exp=1/0/0", rsp_err, rsp_timeout, psel); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL unaligned_after valid=%b ready=%b exp=0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_reset_in_access();
        int seen = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h04; cmd_wdata = '0;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        total++; if (penable !== 1'b1) begin bad++; $display("FAIL rst_access penable=%b exp=1", penable); end
        preset = 1'b1;
        @(negedge clk);
        total++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_drop psel=%b pen=%b valid=%b exp=000", psel, penable, rsp_valid); end
        preset = 1'b0;
        pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid || psel) seen++;
        end
        pready = 1'b0;
        total++; if (seen != 0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_after stray=%0d ready=%b exp=0/1", seen, cmd_ready); end
    endtask

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        test_reset();
        test_write_wait();
        test_read_back_to_back();
        test_slverr();
        test_timeout();
        test_unaligned();
        test_reset_in_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
